// File: rtl/scoreboard_mc_pkg.sv
//------------------------------------------------------------------------------
// Module  : scoreboard_mc_pkg
// Purpose : Shared definitions for the multi-channel scoreboard: the
//           controller state enumeration and the default counter width.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package scoreboard_mc_pkg;

  // Controller states: collect/compare, one-cycle leftover tally, final hold.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } sb_state_e;

  localparam int CNT_W_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/scoreboard_mc_if.sv
//------------------------------------------------------------------------------
// Module  : scoreboard_mc_if
// Purpose : Per-channel expected/actual data bus of the scoreboard.
// Signals : i_exp_valid/i_exp_data/o_exp_ready - expected-data push handshake
//           i_act_valid/i_act_data             - observed DUT output
//           Channel c occupies bits [c*SIZE_DATA +: SIZE_DATA] of the data
//           vectors. master = stimulus side, slave = scoreboard side.
// Config  : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface scoreboard_mc_if #(
  parameter int SIZE_DATA = 8,
  parameter int NUM_CH    = 2
);

  logic [NUM_CH-1:0]           i_exp_valid;
  logic [NUM_CH*SIZE_DATA-1:0] i_exp_data;
  logic [NUM_CH-1:0]           o_exp_ready;
  logic [NUM_CH-1:0]           i_act_valid;
  logic [NUM_CH*SIZE_DATA-1:0] i_act_data;

  modport master (
    output i_exp_valid, i_exp_data, i_act_valid, i_act_data,
    input  o_exp_ready
  );

  modport slave (
    input  i_exp_valid, i_exp_data, i_act_valid, i_act_data,
    output o_exp_ready
  );

endinterface

`default_nettype wire

// File: rtl/sb_fifo.sv
//------------------------------------------------------------------------------
// Module  : sb_fifo
// Purpose : Synchronous FIFO holding the expected entries of one channel.
//           Head is presented combinationally on dout (show-ahead).
// Ports   : clk, rst_n (sync, active-low), push/din, pop/dout,
//           full, empty, count (occupancy, 0..DEPTH)
// Config  : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/scoreboard_mc.sv
//------------------------------------------------------------------------------
// Module  : scoreboard_mc
// Purpose : Multi-channel in-order scoreboard. Each channel queues expected
//           data and compares it against observed data; results are tallied
//           in saturating counters and summarised after an end-of-test request.
// Ports   : i_clk, i_rst_n (sync, active-low)
//           bus      - scoreboard_mc_if.slave (expected/actual per channel)
//           i_finish - end-of-test request
//           o_total_cnt/o_pass_cnt/o_fail_cnt/o_miss_cnt - result counters
//           o_err_ovf/o_err_unf - sticky per-channel overflow/underflow
//           o_done, o_all_pass  - summary valid / all checks clean
// Config  : SCOREBOARD_MC_DISPLAY_EN - when defined, prints every compare and
//           a final summary in simulation.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module scoreboard_mc
  import scoreboard_mc_pkg::*;
#(
  parameter int SIZE_DATA = 8,
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  scoreboard_mc_if.slave     bus,
  input  logic               i_finish,
  output logic [CNT_W-1:0]   o_total_cnt,
  output logic [CNT_W-1:0]   o_pass_cnt,
  output logic [CNT_W-1:0]   o_fail_cnt,
  output logic [CNT_W-1:0]   o_miss_cnt,
  output logic [NUM_CH-1:0]  o_err_ovf,
  output logic [NUM_CH-1:0]  o_err_unf,
  output logic               o_done,
  output logic               o_all_pass
);

  localparam int CW    = $clog2(DEPTH) + 1;
  // Wide enough for the sum of up to eight occupancies and for the
  // saturation threshold itself.
  localparam int SUM_W = ((CNT_W > CW + 3) ? CNT_W : CW + 3) + 1;

  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_CHECK = CHECK;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]           state;
  logic                 run;
  logic [NUM_CH-1:0]    full;
  logic [NUM_CH-1:0]    empty;
  logic [NUM_CH-1:0]    push;
  logic [NUM_CH-1:0]    pop;
  logic [NUM_CH-1:0]    cmp;
  logic [NUM_CH-1:0]    hit;
  logic [SIZE_DATA-1:0] head [NUM_CH];
  logic [CW-1:0]        occ  [NUM_CH];
  logic [3:0]           n_cmp;
  logic [3:0]           n_pass;
  logic [3:0]           n_fail;
  logic [SUM_W-1:0]     occ_sum;
  logic [CNT_W-1:0]     miss_sat;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign run             = (state == ST_RUN);
  assign bus.o_exp_ready = {NUM_CH{run}} & ~full;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      sb_fifo #(
        .WIDTH (SIZE_DATA),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push[c]),
        .din   (bus.i_exp_data[c*SIZE_DATA +: SIZE_DATA]),
        .pop   (pop[c]),
        .dout  (head[c]),
        .full  (full[c]),
        .empty (empty[c]),
        .count (occ[c])
      );

      // Every observed beat in RUN is a compare, even against an empty
      // queue; only a non-empty queue is popped. A same-cycle push is
      // written behind the head and never bypassed to the compare.
      assign cmp[c]  = run && bus.i_act_valid[c];
      assign push[c] = run && bus.i_exp_valid[c] && !full[c];
      assign pop[c]  = cmp[c] && !empty[c];
      assign hit[c]  = pop[c] && (head[c] == bus.i_act_data[c*SIZE_DATA +: SIZE_DATA]);
    end
  endgenerate

  assign n_cmp  = 4'($countones(cmp));
  assign n_pass = 4'($countones(hit));
  assign n_fail = n_cmp - n_pass;

  always_comb begin
    occ_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      occ_sum = occ_sum + SUM_W'(occ[c]);
    end
  end

  assign miss_sat = (occ_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                       : occ_sum[CNT_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_RUN;
      o_total_cnt <= '0;
      o_pass_cnt  <= '0;
      o_fail_cnt  <= '0;
      o_miss_cnt  <= '0;
      o_err_ovf   <= '0;
      o_err_unf   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          o_total_cnt <= sat_add(o_total_cnt, n_cmp);
          o_pass_cnt  <= sat_add(o_pass_cnt, n_pass);
          o_fail_cnt  <= sat_add(o_fail_cnt, n_fail);
          o_err_ovf   <= o_err_ovf | (bus.i_exp_valid & full);
          o_err_unf   <= o_err_unf | (cmp & empty);
          if (i_finish) state <= ST_CHECK;
        end
        ST_CHECK: begin
          o_miss_cnt <= miss_sat;
          state      <= ST_DONE;
        end
        // DONE holds until reset; the unused encoding parks there too.
        default: state <= ST_DONE;
      endcase
    end
  end

  assign o_done     = (state == ST_DONE);
  assign o_all_pass = o_done && (o_fail_cnt == '0) && (o_miss_cnt == '0) &&
                      (o_err_ovf == '0) && (o_err_unf == '0) &&
                      (o_total_cnt != '0);

`ifdef SCOREBOARD_MC_DISPLAY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cmp[c]) begin
          if (empty[c])
            $display("%0t scoreboard_mc ch%0d FAIL exp=<empty> act=%h", $time, c,
                     bus.i_act_data[c*SIZE_DATA +: SIZE_DATA]);
          else
            $display("%0t scoreboard_mc ch%0d %s exp=%h act=%h", $time, c,
                     hit[c] ? "PASS" : "FAIL", head[c],
                     bus.i_act_data[c*SIZE_DATA +: SIZE_DATA]);
        end
      end
      if (state == ST_CHECK) begin
        $display("%0t scoreboard_mc summary total=%0d pass=%0d fail=%0d miss=%0d pass_rate=%0d%%",
                 $time, o_total_cnt, o_pass_cnt, o_fail_cnt, miss_sat,
                 (o_total_cnt == '0) ? 0 : (int'(o_pass_cnt) * 100) / int'(o_total_cnt));
      end
    end
  end
`else
  // Default build is silent in simulation.
`endif

endmodule

`default_nettype wire

// File: doc/scoreboard_mc.md
SCOREBOARD_MC -- requirements
Module: scoreboard_mc

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, data width per channel.
REQ-002 SHALL have parameter NUM_CH, default 2, number of independent compare channels (1..8).
REQ-003 SHALL have parameter DEPTH, default 8, expected-queue entries per channel (power of 2, >=2).
REQ-004 SHALL have parameter CNT_W, default 16, width of all result counters.
REQ-005 SHALL have port i_clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port i_rst_n, input, 1: synchronous active-low reset.
REQ-007 SHALL have port i_exp_valid, input, NUM_CH: per-channel expected-data push request.
REQ-008 SHALL have port i_exp_data, input, NUM_CH*SIZE_DATA: expected data; channel c in bits [c*SIZE_DATA +: SIZE_DATA].
REQ-009 SHALL have port o_exp_ready, output, NUM_CH: per-channel queue not full.
REQ-010 SHALL have port i_act_valid, input, NUM_CH: per-channel DUT output valid.
REQ-011 SHALL have port i_act_data, input, NUM_CH*SIZE_DATA: DUT output data, same packing as i_exp_data.
REQ-012 SHALL have port i_finish, input, 1: end-of-test request.
REQ-013 SHALL have ports o_total_cnt, o_pass_cnt, o_fail_cnt, o_miss_cnt, output, CNT_W each: compares, matches, mismatches, unmatched leftover expected entries.
REQ-014 SHALL have ports o_err_ovf, o_err_unf, output, NUM_CH each: sticky per-channel overflow / underflow flags.
REQ-015 SHALL have ports o_done, o_all_pass, output, 1 each: summary valid; all checks clean.

Function
REQ-016 Push accepted on channel c iff i_exp_valid[c] && o_exp_ready[c]; o_exp_ready[c] = !full[c], independent of same-cycle pop.
REQ-017 Push while full SHALL drop the data and set o_err_ovf[c].
REQ-018 Compare on channel c when i_act_valid[c] and queue non-empty: pop head, compare head to i_act_data slice; pass if equal.
REQ-019 i_act_valid[c] with queue empty SHALL count as fail, increment total, set o_err_unf[c]; same-cycle push is not bypassed to the compare.
REQ-020 Simultaneous push and pop on a non-full, non-empty queue SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-021 Multiple channels comparing in one cycle SHALL add the popcount of passes/fails/compares to the counters in that cycle.
REQ-022 Counters SHALL update on the clock edge ending the compare cycle (latency 1) and SHALL saturate at 2^CNT_W-1.
REQ-023 FSM states RUN, CHECK, DONE; RUN->CHECK on i_finish; CHECK->DONE after one cycle; DONE held until reset.
REQ-024 In CHECK, o_miss_cnt SHALL load the sum of all queue occupancies (saturating).
REQ-025 Outside RUN, pushes and compares SHALL be ignored, o_exp_ready all 0; i_finish in CHECK/DONE ignored.
REQ-026 o_done SHALL be 1 only in DONE; o_all_pass = o_done && fail==0 && miss==0 && no err flag set && total>0.

Reset
REQ-027 i_rst_n low at any edge SHALL empty all queues, zero all counters, clear err flags, o_done=0, o_all_pass=0, state RUN, o_exp_ready all 1 in the first cycle after release, including mid-operation.

Configuration
REQ-028 With SCOREBOARD_MC_DISPLAY_EN defined, SHALL $display each compare (time, channel, PASS/FAIL, expected, actual) and, on entering DONE, a summary of total/pass/fail/miss/pass-rate.
REQ-029 Without SCOREBOARD_MC_DISPLAY_EN, SHALL produce no simulation output; ports and counters identical.

Structure
REQ-030 Package scoreboard_mc_pkg SHALL hold the state enum (RUN, CHECK, DONE) and CNT_W default constant.
REQ-031 Per-channel queue SHALL be sub-module sb_fifo (synchronous FIFO, SIZE_DATA x DEPTH, full/empty/count), instantiated NUM_CH times by generate.

Verification
REQ-032 Ch0 push 0x11,0x22; act 0x11,0x22 -> total=2, pass=2; finish -> o_done=1, o_all_pass=1.
REQ-033 Ch1 push 0x5A; act 0x5B -> fail=1, o_all_pass=0 after finish.
REQ-034 Ch0 push 9 entries back-to-back (DEPTH=8) -> 9th dropped, o_err_ovf[0]=1, o_exp_ready[0]=0 while full.
REQ-035 Both channels compare matching data same cycle -> total +2, pass +2 in one edge; act on empty ch1 -> o_err_unf[1]=1.
REQ-036 Push 3 entries, compare 1, finish -> o_miss_cnt=2, o_done one cycle after CHECK.
REQ-037 Reset asserted with queues half full mid-run -> all counters 0, flags 0, state RUN, queues empty.
